amba3_apb_slave_regs: RTL and testbench

//  Synthesizable AMBA 3 APB slave (completer) that answers the amba3_apb_if master

---
 rtl/amba3_apb_slave_regs.sv | 165 ++++++++++++++++
 tb/tb_amba3_apb_slave_regs.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/amba3_apb_slave_regs.sv
// ---------------------------------------------------------------------------
// amba3_apb_slave_regs
//   AMBA 3 APB completer holding a bank of read/write word registers plus a
//   window of read-only words sourced from local hardware. A fixed number of
//   wait states is inserted through pready before each transfer completes.
//
// Ports
//   pclk      in   clock, all logic on the rising edge
//   preset    in   synchronous reset, active-high
//   paddr     in   byte address (only the low 4 KB page is decoded)
//   psel      in   slave select from the bridge/decoder
//   penable   in   access phase
//   pwrite    in   1 = write, 0 = read
//   pwdata    in   write data
//   pready    out  transfer complete (registered)
//   prdata    out  read data, valid while pready = 1 (registered)
//   reg_q     out  RW register contents, reg i at [i*DATA_BITS +: DATA_BITS]
//   wr_pulse  out  one-cycle pulse, bit i set in the cycle after reg i is written
//   ro_d      in   RO register sources, RO j at [j*DATA_BITS +: DATA_BITS]
// ---------------------------------------------------------------------------
module amba3_apb_slave_regs #(
  parameter int                   ADDR_BITS   = 32,
  parameter int                   DATA_BITS   = 32,
  parameter int                   NUM_RW      = 8,
  parameter int                   NUM_RO      = 4,
  parameter int                   WAIT_STATES = 0,
  parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic [ADDR_BITS-1:0]        paddr,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [DATA_BITS-1:0]        pwdata,
  output logic                        pready,
  output logic [DATA_BITS-1:0]        prdata,
  output logic [NUM_RW*DATA_BITS-1:0] reg_q,
  output logic [NUM_RW-1:0]           wr_pulse,
  input  logic [NUM_RO*DATA_BITS-1:0] ro_d
);

  // Byte-offset bits below a word are ignored. Address bits above the 4 KB
  // peripheral page belong to the bridge's slot decode, so 0x100C and 0x000C
  // reach the same register.
  localparam int OFF_BITS = $clog2(DATA_BITS / 8);
  localparam int WIN_BITS = (ADDR_BITS < 12) ? ADDR_BITS : 12;
  localparam int IDX_BITS = WIN_BITS - OFF_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic [IDX_BITS-1:0]  r_idx;
  logic                 r_write;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] r_regs [NUM_RW];

  logic [IDX_BITS-1:0]  w_addr_idx;
  logic [IDX_BITS-1:0]  w_rd_idx;
  logic [DATA_BITS-1:0] w_rd_data;
  logic                 w_unused_addr;

  assign w_addr_idx    = paddr[WIN_BITS-1:OFF_BITS];
  assign w_unused_addr = ^paddr;

  // With no wait states READY is entered on the setup edge itself, before the
  // index has been latched, so the read mux looks at the live address then.
  assign w_rd_idx = (r_state == S_IDLE) ? w_addr_idx : r_idx;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // an unmatched index would infer a latch.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_rd_idx == IDX_BITS'(i)) w_rd_data = r_regs[i];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (w_rd_idx == IDX_BITS'(NUM_RW + j)) w_rd_data = ro_d[j*DATA_BITS +: DATA_BITS];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      pready   <= 1'b0;
      prdata   <= '0;
      wr_pulse <= '0;
      // NOTE: the register bank is discrete flops, not a RAM, so it carries a
      // reset value like any other state.
      for (int i = 0; i < NUM_RW; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      wr_pulse <= '0;
      case (r_state)
        S_IDLE: begin
          // penable without a preceding setup does not start a transfer.
          if (psel && !penable) begin
            r_idx   <= w_addr_idx;
            r_write <= pwrite;
            r_wdata <= pwdata;
            if (WAIT_STATES == 0) begin
              r_state <= S_READY;
              pready  <= 1'b1;
              prdata  <= w_rd_data;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_READY;
              pready  <= 1'b1;
              prdata  <= w_rd_data;
            end
          end
        end
        S_READY: begin
          if (!psel) begin
            // Abort: the master walked away, nothing is committed.
            r_state <= S_IDLE;
            pready  <= 1'b0;
            prdata  <= '0;
          end else if (penable) begin
            if (r_write) begin
              // Only RW indices match here; RO and out-of-range writes drop.
              for (int i = 0; i < NUM_RW; i++) begin
                if (r_idx == IDX_BITS'(i)) begin
                  r_regs[i]   <= r_wdata;
                  wr_pulse[i] <= 1'b1;
                end
              end
            end
            r_state <= S_IDLE;
            pready  <= 1'b0;
            prdata  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          pready  <= 1'b0;
          prdata  <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_reg_q
    assign reg_q[gi*DATA_BITS +: DATA_BITS] = r_regs[gi];
  end

endmodule

// File: tb/tb_amba3_apb_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_amba3_apb_slave_regs
//   Directed bench for amba3_apb_slave_regs. Two instances share the APB bus
//   signals but have their own psel/preset: dut0 runs with no wait states and
//   a non-zero RW reset value, dut3 runs with three wait states.
// ---------------------------------------------------------------------------
module tb_amba3_apb_slave_regs;

  localparam logic [31:0] RV0 = 32'h0000_1234;
  localparam logic [31:0] RV3 = 32'h0000_0000;

  logic         pclk = 1'b0;
  logic         preset0, preset3;
  logic [31:0]  paddr;
  logic         psel0, psel3, penable, pwrite;
  logic [31:0]  pwdata;
  logic         pready0, pready3;
  logic [31:0]  prdata0, prdata3;
  logic [255:0] reg_q0, reg_q3;
  logic [7:0]   wr_pulse0, wr_pulse3;
  logic [127:0] ro_d0, ro_d3;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] exp_q0;
  logic [255:0] exp_q3;

  always #5 pclk = ~pclk;

  amba3_apb_slave_regs #(
    .WAIT_STATES(0), .RESET_VALUE(RV0)
  ) dut0 (
    .pclk(pclk), .preset(preset0), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0),
    .reg_q(reg_q0), .wr_pulse(wr_pulse0), .ro_d(ro_d0)
  );

  amba3_apb_slave_regs #(
    .WAIT_STATES(3), .RESET_VALUE(RV3)
  ) dut3 (
    .pclk(pclk), .preset(preset3), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready3), .prdata(prdata3),
    .reg_q(reg_q3), .wr_pulse(wr_pulse3), .ro_d(ro_d3)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic f_pready(input int d);
    return (d == 0) ? pready0 : pready3;
  endfunction

  function automatic logic [31:0] f_prdata(input int d);
    return (d == 0) ? prdata0 : prdata3;
  endfunction

  task automatic bus_idle();
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  // Starts a setup phase immediately (caller is #1 past an edge) and returns
  // #1 after the completing edge with psel still high, so a following call
  // forms a back-to-back transfer. Address/data are scrambled during access.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int acc_cycles);
    int n;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    penable = 1'b0;
    if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = addr ^ 32'h0000_0FFC;
    pwdata  = ~wdata;
    rdata   = '0;
    n       = 0;
    acc_cycles = 0;
    while (n < 20) begin
      n++;
      if (f_pready(d)) begin
        rdata      = f_prdata(d);
        acc_cycles = n;
        break;
      end
      @(posedge pclk); #1;
    end
    if (acc_cycles == 0) check("pready_timeout", 0, 1);
    @(posedge pclk); #1;
  endtask

  logic [31:0] rd;
  int          acc;
  int          n_wait;

  initial begin
    ro_d0 = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    ro_d3 = {32'h7777_0003, 32'h7777_0002, 32'h5A5A_0001, 32'h7777_0000};
    paddr = '0; pwrite = 1'b0; pwdata = '0;
    bus_idle();
    preset0 = 1'b1;
    preset3 = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    preset0 = 1'b0;
    preset3 = 1'b0;
    exp_q0 = {8{RV0}};
    exp_q3 = {8{RV3}};

    // 1: reset state and RW reads
    check("rst_pready0", pready0, 0);
    check("rst_prdata0", prdata0, 0);
    check("rst_wr_pulse0", wr_pulse0, 0);
    check("rst_reg_q0", reg_q0, exp_q0);
    check("rst_reg_q3", reg_q3, exp_q3);
    for (int i = 0; i < 8; i++) begin
      apb_xfer(0, 1'b0, 32'(i * 4), 32'h0, rd, acc);
      check($sformatf("rst_rd_idx%0d", i), rd, RV0);
    end
    bus_idle();

    // 2: zero-wait write, upper page bits ignored
    apb_xfer(0, 1'b1, 32'h0000_100C, 32'hDEAD_BEEF, rd, acc);
    exp_q0[3*32 +: 32] = 32'hDEAD_BEEF;
    check("w0_acc_cycles", acc, 1);
    check("w0_wr_pulse", wr_pulse0, 8'b0000_1000);
    check("w0_reg_q", reg_q0, exp_q0);
    check("w0_pready_after", pready0, 0);
    bus_idle();
    @(posedge pclk); #1;
    check("w0_wr_pulse_clear", wr_pulse0, 0);
    apb_xfer(0, 1'b0, 32'h0000_000C, 32'h0, rd, acc);
    check("w0_readback", rd, 32'hDEAD_BEEF);
    bus_idle();

    // 3: three wait states, RO read
    apb_xfer(3, 1'b0, 32'h0000_0024, 32'h0, rd, acc);
    check("ws3_access_cycles", acc, 4);
    check("ws3_psel_cycles", acc + 1, 5);
    check("ws3_ro_read", rd, 32'h5A5A_0001);
    bus_idle();

    // 4: RO and out-of-range writes drop silently
    apb_xfer(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, rd, acc);
    check("ro_wr_acc", acc, 1);
    check("ro_wr_pulse", wr_pulse0, 0);
    apb_xfer(0, 1'b1, 32'h0000_0050, 32'hFFFF_FFFF, rd, acc);
    check("oor_wr_acc", acc, 1);
    check("oor_wr_pulse", wr_pulse0, 0);
    check("ro_oor_reg_q", reg_q0, exp_q0);
    apb_xfer(0, 1'b0, 32'h0000_0050, 32'h0, rd, acc);
    check("oor_read", rd, 0);
    apb_xfer(0, 1'b0, 32'h0000_0020, 32'h0, rd, acc);
    check("ro_idx8_read", rd, 32'hC0DE_0000);
    bus_idle();

    // penable without setup is ignored
    paddr = 32'h0000_0004; pwrite = 1'b1; pwdata = 32'hBAD0_BAD0;
    psel0 = 1'b1; penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check($sformatf("noset_pready%0d", i), pready0, 0);
    end
    bus_idle();
    @(posedge pclk); #1;
    check("noset_reg_q", reg_q0, exp_q0);
    check("noset_wr_pulse", wr_pulse0, 0);

    // 5: back-to-back write then read
    apb_xfer(0, 1'b1, 32'h0000_0004, 32'h0000_0011, rd, acc);
    exp_q0[1*32 +: 32] = 32'h0000_0011;
    check("b2b_wr_pulse", wr_pulse0, 8'b0000_0010);
    apb_xfer(0, 1'b0, 32'h0000_0004, 32'h0, rd, acc);
    check("b2b_read", rd, 32'h0000_0011);
    check("b2b_read_acc", acc, 1);
    check("b2b_reg_q", reg_q0, exp_q0);
    bus_idle();

    // 6a: a committed wait-state write, then reset during WAIT of another
    apb_xfer(3, 1'b1, 32'h0000_0008, 32'h0000_0033, rd, acc);
    exp_q3[2*32 +: 32] = 32'h0000_0033;
    check("ws3_wr_acc", acc, 4);
    check("ws3_wr_pulse", wr_pulse3, 8'b0000_0100);
    check("ws3_wr_reg_q", reg_q3, exp_q3);
    bus_idle();
    @(posedge pclk); #1;
    paddr = 32'h0000_0008; pwrite = 1'b1; pwdata = 32'h0000_0022;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset3 = 1'b1;
    @(posedge pclk); #1;
    preset3 = 1'b0;
    bus_idle();
    exp_q3 = {8{RV3}};
    check("rstwait_pready", pready3, 0);
    check("rstwait_prdata", prdata3, 0);
    check("rstwait_reg_q", reg_q3, exp_q3);
    @(posedge pclk); #1;
    check("rstwait_wr_pulse", wr_pulse3, 0);
    check("rstwait_reg_q_late", reg_q3, exp_q3);

    // 6b: psel dropped while READY -> no write
    paddr = 32'h0000_0008; pwrite = 1'b1; pwdata = 32'h0000_0044;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    n_wait = 0;
    while (!pready3 && n_wait < 20) begin
      @(posedge pclk); #1;
      n_wait++;
    end
    check("abort_ready_reached", pready3, 1);
    bus_idle();
    @(posedge pclk); #1;
    check("abort_pready", pready3, 0);
    check("abort_wr_pulse", wr_pulse3, 0);
    check("abort_reg_q", reg_q3, exp_q3);
    apb_xfer(3, 1'b0, 32'h0000_0008, 32'h0, rd, acc);
    check("abort_readback", rd, RV3);
    bus_idle();
    @(posedge pclk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
